// File: rtl/calc_pkg.sv
// ---------------------------------------------------------------------------
// calc_pkg -- shared types and constants for the calculator key-entry stage.
//   op_t    : operator code presented to the arithmetic unit.
//   KEY_*   : key indices within the scanner's 16-bit key_pulse vector.
//   state_t : key_entry sequencing states.
// ---------------------------------------------------------------------------
package calc_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_t;

  localparam logic [3:0] KEY_ADD = 4'd10;
  localparam logic [3:0] KEY_SUB = 4'd11;
  localparam logic [3:0] KEY_MUL = 4'd12;
  localparam logic [3:0] KEY_DIV = 4'd13;
  localparam logic [3:0] KEY_EQ  = 4'd14;
  localparam logic [3:0] KEY_CLR = 4'd15;

  typedef enum logic [2:0] {
    S_A,
    S_OP,
    S_B,
    S_REQ,
    S_WAIT,
    S_RES
  } state_t;

  function automatic logic key_is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

  function automatic logic key_is_op(input logic [3:0] code);
    return (code >= KEY_ADD) && (code <= KEY_DIV);
  endfunction

endpackage

// File: rtl/key_entry_if.sv
// ---------------------------------------------------------------------------
// key_entry_if -- compute request / result channel between key_entry and the
// arithmetic unit.
//   req_valid/req_ready : request handshake (master drives valid)
//   req_a/req_b         : BCD operands, 4*DIGITS bits
//   req_op              : operator (op_t)
//   res_valid/res_bcd   : result strobe and BCD result (slave drives)
// Modports: master = key_entry side, slave = arithmetic unit side.
// ---------------------------------------------------------------------------
interface key_entry_if #(
  parameter int unsigned DIGITS = 4
);
  import calc_pkg::*;

  localparam int unsigned W = 4 * DIGITS;

  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;
  op_t          req_op;
  logic         res_valid;
  logic [W-1:0] res_bcd;

  modport master (
    output req_valid, req_a, req_b, req_op,
    input  req_ready, res_valid, res_bcd
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op,
    output req_ready, res_valid, res_bcd
  );

endinterface

// File: rtl/key_entry_enc.sv
// ---------------------------------------------------------------------------
// key_enc -- combinational priority encoder for the scanner key strobes.
//   i_strobe : 16 one-cycle key strobes
//   o_code   : index of the lowest set strobe (0 when none)
//   o_vld    : any strobe set
//   o_multi  : more than one strobe set
// ---------------------------------------------------------------------------
module key_enc (
  input  logic [15:0] i_strobe,
  output logic [3:0]  o_code,
  output logic        o_vld,
  output logic        o_multi
);

  always_comb begin
    o_code = '0;
    // Scan from the top so the lowest set index is written last and wins.
    for (int unsigned i = 0; i < 16; i++) begin
      if (i_strobe[15 - i]) o_code = 4'(15 - i);
    end
  end

  assign o_vld   = |i_strobe;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign o_multi = |(i_strobe & (i_strobe - 16'd1));

endmodule

// File: rtl/key_entry.sv
// ---------------------------------------------------------------------------
// key_entry -- operand/operator entry stage of the calculator.
// Builds two BCD operands and an operator from scanner keystrokes, issues a
// compute request over a valid/ready channel and loads the returned result.
//   clk, rst_n : clock, asynchronous active-low reset
//   key_pulse  : one-cycle key strobes (0-9 digits, 10-13 + - * /, 14 =, 15 C)
//   bus        : key_entry_if.master request/result channel
//   disp_bcd   : registered value for the display
//   ovf        : sticky entry-error flag
// Build option: define KEY_ENTRY_OVF_EN to enable ovf detection (dropped
// digit or multi-key pulse); otherwise ovf is tied to 0.
// ---------------------------------------------------------------------------
module key_entry
  import calc_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [15:0]           key_pulse,
  key_entry_if.master           bus,
  output logic [4*DIGITS-1:0]   disp_bcd,
  output logic                  ovf
);

  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned CW = $clog2(DIGITS + 1);
  localparam logic [CW-1:0] FULL = CW'(DIGITS);

  logic [3:0] w_code;
  logic       w_vld;
`ifdef KEY_ENTRY_OVF_EN
  logic       w_multi;
`else
  logic       w_multi_unused;
`endif

  key_enc u_enc (
    .i_strobe (key_pulse),
    .o_code   (w_code),
    .o_vld    (w_vld),
`ifdef KEY_ENTRY_OVF_EN
    .o_multi  (w_multi)
`else
    .o_multi  (w_multi_unused)
`endif
  );

  state_t        r_state, w_state_nxt;
  logic [W-1:0]  r_a, r_b, w_a_nxt, w_b_nxt;
  logic [CW-1:0] r_cnt_a, r_cnt_b, w_cnt_a_nxt, w_cnt_b_nxt;
  op_t           r_op, w_op_nxt;
  logic [W-1:0]  r_disp, w_disp_nxt;
  logic          r_req_valid;

  logic w_digit, w_oper, w_eq, w_clr;
  op_t  w_key_op;

  assign w_digit  = w_vld && key_is_digit(w_code);
  assign w_oper   = w_vld && key_is_op(w_code);
  assign w_eq     = w_vld && (w_code == KEY_EQ);
  assign w_clr    = w_vld && (w_code == KEY_CLR);
  assign w_key_op = op_t'(2'(w_code - KEY_ADD));

  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_cnt_a_nxt = r_cnt_a;
    w_cnt_b_nxt = r_cnt_b;
    w_op_nxt    = r_op;

    unique case (r_state)
      S_A: begin
        if (w_digit) begin
          if (r_cnt_a != FULL) begin
            w_a_nxt = {r_a[W-5:0], w_code};
            // Leading zeros do not count as entered digits.
            if (!(r_a == '0 && w_code == 4'd0)) w_cnt_a_nxt = r_cnt_a + CW'(1);
          end
        end else if (w_oper) begin
          w_op_nxt    = w_key_op;
          w_state_nxt = S_OP;
        end
      end
      S_OP: begin
        if (w_oper) begin
          w_op_nxt = w_key_op;
        end else if (w_digit) begin
          w_b_nxt     = {{(W-4){1'b0}}, w_code};
          w_cnt_b_nxt = (w_code == 4'd0) ? '0 : CW'(1);
          w_state_nxt = S_B;
        end
      end
      S_B: begin
        if (w_digit) begin
          if (r_cnt_b != FULL) begin
            w_b_nxt = {r_b[W-5:0], w_code};
            if (!(r_b == '0 && w_code == 4'd0)) w_cnt_b_nxt = r_cnt_b + CW'(1);
          end
        end else if (w_eq) begin
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (bus.req_ready) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // C is handled below and takes priority over a coincident result.
        if (bus.res_valid) begin
          w_a_nxt     = bus.res_bcd;
          w_cnt_a_nxt = FULL;
          w_state_nxt = S_RES;
        end
      end
      S_RES: begin
        if (w_digit) begin
          w_a_nxt     = {{(W-4){1'b0}}, w_code};
          w_cnt_a_nxt = (w_code == 4'd0) ? '0 : CW'(1);
          w_state_nxt = S_A;
        end else if (w_oper) begin
          w_op_nxt    = w_key_op;
          w_state_nxt = S_OP;
        end
      end
      default: w_state_nxt = S_A;
    endcase

    if (w_clr && r_state != S_REQ) begin
      w_a_nxt     = '0;
      w_b_nxt     = '0;
      w_cnt_a_nxt = '0;
      w_cnt_b_nxt = '0;
      w_op_nxt    = OP_ADD;
      w_state_nxt = S_A;
    end

    unique case (w_state_nxt)
      S_B, S_REQ, S_WAIT: w_disp_nxt = w_b_nxt;
      default:            w_disp_nxt = w_a_nxt;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_A;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a         <= '0;
      r_b         <= '0;
      r_cnt_a     <= '0;
      r_cnt_b     <= '0;
      r_op        <= OP_ADD;
      r_disp      <= '0;
      r_req_valid <= 1'b0;
    end else begin
      r_a         <= w_a_nxt;
      r_b         <= w_b_nxt;
      r_cnt_a     <= w_cnt_a_nxt;
      r_cnt_b     <= w_cnt_b_nxt;
      r_op        <= w_op_nxt;
      r_disp      <= w_disp_nxt;
      r_req_valid <= (w_state_nxt == S_REQ);
    end
  end

`ifdef KEY_ENTRY_OVF_EN
  logic r_ovf;
  logic w_drop, w_clr_all;

  assign w_drop = w_digit && ((r_state == S_A && r_cnt_a == FULL) ||
                              (r_state == S_B && r_cnt_b == FULL));
  assign w_clr_all = w_clr && (r_state != S_REQ);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_ovf <= 1'b0;
    else if (w_clr_all) r_ovf <= 1'b0;
    else if (w_drop || w_multi) r_ovf <= 1'b1;
  end

  assign ovf = r_ovf;
`else
  assign ovf = 1'b0;
`endif

  assign bus.req_valid = r_req_valid;
  assign bus.req_a     = r_a;
  assign bus.req_b     = r_b;
  assign bus.req_op    = r_op;
  assign disp_bcd      = r_disp;

endmodule

// File: tb/tb_key_entry.sv
module tb_key_entry;
  import calc_pkg::*;

  localparam int unsigned DIGITS = 4;
`ifdef KEY_ENTRY_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  localparam int PH_A = 0, PH_OP = 1, PH_B = 2, PH_REQ = 3, PH_WAIT = 4, PH_RES = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] key_pulse = '0;
  logic [15:0] disp_bcd;
  logic        ovf;

  key_entry_if #(.DIGITS(DIGITS)) bus();

  key_entry #(.DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_pulse (key_pulse),
    .bus       (bus.master),
    .disp_bcd  (disp_bcd),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: operands held as decimal integers plus digit counts.
  int m_ph, m_a, m_b, m_na, m_nb, m_op;
  bit m_ovf;

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int t = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int from_bcd(input logic [15:0] b);
    int v = 0;
    for (int i = 3; i >= 0; i--) v = v * 10 + int'(b[4*i +: 4]);
    return v;
  endfunction

  function automatic logic [15:0] K(input int i);
    logic [15:0] one = 16'd1;
    return one << i;
  endfunction

  function automatic void model_clear();
    m_ph = PH_A; m_a = 0; m_b = 0; m_na = 0; m_nb = 0; m_op = 0; m_ovf = 1'b0;
  endfunction

  function automatic void enter(inout int v, inout int n, input int d);
    if (n >= 4) begin
      if (OVF_EN) m_ovf = 1'b1;
    end else begin
      if (!(v == 0 && d == 0)) n = n + 1;
      v = v * 10 + d;
    end
  endfunction

  function automatic void model_step(input logic [15:0] kp, input logic rdy,
                                     input logic rv, input logic [15:0] rb);
    int key = -1;
    bit is_dig, is_op, is_eq, is_c;
    for (int i = 15; i >= 0; i--) if (kp[i]) key = i;
    is_dig = (key >= 0) && (key <= 9);
    is_op  = (key >= 10) && (key <= 13);
    is_eq  = (key == 14);
    is_c   = (key == 15);
    if (OVF_EN && $countones(kp) > 1) m_ovf = 1'b1;
    case (m_ph)
      PH_A: begin
        if (is_c) model_clear();
        else if (is_dig) enter(m_a, m_na, key);
        else if (is_op) begin m_op = key - 10; m_ph = PH_OP; end
      end
      PH_OP: begin
        if (is_c) model_clear();
        else if (is_op) m_op = key - 10;
        else if (is_dig) begin m_b = 0; m_nb = 0; enter(m_b, m_nb, key); m_ph = PH_B; end
      end
      PH_B: begin
        if (is_c) model_clear();
        else if (is_dig) enter(m_b, m_nb, key);
        else if (is_eq) m_ph = PH_REQ;
      end
      PH_REQ: if (rdy) m_ph = PH_WAIT;
      PH_WAIT: begin
        if (is_c) model_clear();
        else if (rv) begin m_a = from_bcd(rb); m_na = 4; m_ph = PH_RES; end
      end
      default: begin
        if (is_c) model_clear();
        else if (is_dig) begin m_a = 0; m_na = 0; enter(m_a, m_na, key); m_ph = PH_A; end
        else if (is_op) begin m_op = key - 10; m_ph = PH_OP; end
      end
    endcase
  endfunction

  function automatic logic [15:0] exp_disp();
    if (m_ph == PH_B || m_ph == PH_REQ || m_ph == PH_WAIT) return to_bcd(m_b);
    return to_bcd(m_a);
  endfunction

  task automatic tick(input logic [15:0] kp, input logic rdy, input logic rv,
                      input logic [15:0] rb);
    key_pulse = kp; bus.req_ready = rdy; bus.res_valid = rv; bus.res_bcd = rb;
    @(posedge clk);
    model_step(kp, rdy, rv, rb);
    #1;
    key_pulse = '0; bus.req_ready = 1'b0; bus.res_valid = 1'b0;
  endtask

  task automatic test_reset();
    bus.req_ready = 1'b0; bus.res_valid = 1'b0; bus.res_bcd = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({bus.req_valid, bus.req_op, ovf} !== 4'b0) begin
      n_errors++;
      $display("FAIL reset_ctrl: got valid=%b op=%0d ovf=%b, want 0 0 0", bus.req_valid, bus.req_op, ovf);
    end
    n_checks++;
    if ({bus.req_a, bus.req_b, disp_bcd} !== 48'h0) begin
      n_errors++;
      $display("FAIL reset_data: got a=%h b=%h disp=%h, want 0", bus.req_a, bus.req_b, disp_bcd);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
  endtask

  task automatic test_basic();
    logic [15:0] keys [5];
    logic [15:0] want [5];
    keys = '{K(1), K(2), K(10), K(3), K(14)};
    want = '{16'h0001, 16'h0012, 16'h0012, 16'h0003, 16'h0003};
    for (int i = 0; i < 5; i++) begin
      tick(keys[i], 1'b1, 1'b0, '0);
      n_checks++;
      if (disp_bcd !== want[i]) begin
        n_errors++;
        $display("FAIL basic_disp[%0d]: got %h want %h", i, disp_bcd, want[i]);
      end
    end
    n_checks++;
    if (bus.req_valid !== 1'b1 || bus.req_a !== 16'h0012 || bus.req_b !== 16'h0003 || bus.req_op !== OP_ADD) begin
      n_errors++;
      $display("FAIL basic_req: got v=%b a=%h b=%h op=%0d want 1 0012 0003 0", bus.req_valid, bus.req_a, bus.req_b, bus.req_op);
    end
    tick('0, 1'b1, 1'b0, '0);
    n_checks++;
    if (bus.req_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL basic_hs_drop: got valid=%b want 0", bus.req_valid);
    end
    tick(K(15), 1'b0, 1'b0, '0);
    n_checks++;
    if (disp_bcd !== 16'h0) begin
      n_errors++;
      $display("FAIL basic_clear: got disp=%h want 0000", disp_bcd);
    end
  endtask

  task automatic test_overflow();
    int ds [5] = '{9, 8, 7, 6, 5};
    foreach (ds[i]) tick(K(ds[i]), 1'b0, 1'b0, '0);
    n_checks++;
    if (disp_bcd !== 16'h9876 || ovf !== OVF_EN) begin
      n_errors++;
      $display("FAIL ovf_full: got disp=%h ovf=%b want 9876 %b", disp_bcd, ovf, OVF_EN);
    end
    tick(K(15), 1'b0, 1'b0, '0);
    n_checks++;
    if (disp_bcd !== 16'h0 || ovf !== 1'b0) begin
      n_errors++;
      $display("FAIL ovf_clear: got disp=%h ovf=%b want 0000 0", disp_bcd, ovf);
    end
  endtask

  task automatic test_stall();
    int hi = 0, hs = 0;
    logic rdy;
    tick(K(4), 1'b0, 1'b0, '0);
    tick(K(11), 1'b0, 1'b0, '0);
    tick(K(7), 1'b0, 1'b0, '0);
    tick(K(14), 1'b0, 1'b0, '0);
    for (int i = 0; i < 10; i++) begin
      rdy = (i >= 5);
      if (bus.req_valid === 1'b1) begin
        hi++;
        n_checks++;
        if (bus.req_a !== 16'h0004 || bus.req_b !== 16'h0007 || bus.req_op !== OP_SUB) begin
          n_errors++;
          $display("FAIL stall_stable[%0d]: got a=%h b=%h op=%0d want 0004 0007 1", i, bus.req_a, bus.req_b, bus.req_op);
        end
        if (rdy) hs++;
      end
      tick('0, rdy, 1'b0, '0);
    end
    n_checks++;
    if (hi != 6 || hs != 1) begin
      n_errors++;
      $display("FAIL stall_len: got valid_cycles=%0d handshakes=%0d want 6 1", hi, hs);
    end
  endtask

  task automatic test_result();
    // Entered from S_WAIT left by test_stall.
    tick('0, 1'b0, 1'b1, 16'h0015);
    n_checks++;
    if (disp_bcd !== 16'h0015) begin
      n_errors++;
      $display("FAIL result_disp: got %h want 0015", disp_bcd);
    end
    tick(K(12), 1'b0, 1'b0, '0);
    tick(K(2), 1'b0, 1'b0, '0);
    tick(K(14), 1'b0, 1'b0, '0);
    n_checks++;
    if (bus.req_valid !== 1'b1 || bus.req_a !== 16'h0015 || bus.req_b !== 16'h0002 || bus.req_op !== OP_MUL) begin
      n_errors++;
      $display("FAIL result_chain: got v=%b a=%h b=%h op=%0d want 1 0015 0002 2", bus.req_valid, bus.req_a, bus.req_b, bus.req_op);
    end
    tick('0, 1'b1, 1'b0, '0);
    tick(K(15), 1'b0, 1'b0, '0);
  endtask

  task automatic test_clear_wait();
    tick(K(3), 1'b0, 1'b0, '0);
    tick(K(10), 1'b0, 1'b0, '0);
    tick(K(8), 1'b0, 1'b0, '0);
    tick(K(14), 1'b0, 1'b0, '0);
    tick('0, 1'b1, 1'b0, '0);
    tick(K(15), 1'b0, 1'b0, '0);
    tick('0, 1'b0, 1'b1, 16'h0042);
    n_checks++;
    if (disp_bcd !== 16'h0 || bus.req_valid !== 1'b0 || bus.req_a !== 16'h0) begin
      n_errors++;
      $display("FAIL wait_clear: got disp=%h v=%b a=%h want 0000 0 0000", disp_bcd, bus.req_valid, bus.req_a);
    end
    tick(K(3), 1'b0, 1'b0, '0);
    tick(K(10), 1'b0, 1'b0, '0);
    tick(K(8), 1'b0, 1'b0, '0);
    tick(K(14), 1'b0, 1'b0, '0);
    tick('0, 1'b1, 1'b0, '0);
    tick(K(15), 1'b0, 1'b1, 16'h0042);
    n_checks++;
    if (disp_bcd !== 16'h0) begin
      n_errors++;
      $display("FAIL wait_coincident: got disp=%h want 0000", disp_bcd);
    end
    tick(K(6), 1'b0, 1'b0, '0);
    n_checks++;
    if (disp_bcd !== 16'h0006) begin
      n_errors++;
      $display("FAIL wait_resume: got disp=%h want 0006", disp_bcd);
    end
    tick(K(15), 1'b0, 1'b0, '0);
  endtask

  task automatic test_multi();
    tick(16'h0012, 1'b0, 1'b0, '0);
    n_checks++;
    if (disp_bcd !== 16'h0001 || ovf !== OVF_EN) begin
      n_errors++;
      $display("FAIL multi_key: got disp=%h ovf=%b want 0001 %b", disp_bcd, ovf, OVF_EN);
    end
    tick(K(15), 1'b0, 1'b0, '0);
  endtask

  task automatic test_random();
    logic [15:0] kp, rb;
    logic rdy, rv;
    int r;
    for (int c = 0; c < 600; c++) begin
      r = $urandom_range(0, 9);
      if (r < 5) kp = '0;
      else if (r < 9) kp = K($urandom_range(0, 15));
      else kp = K($urandom_range(0, 15)) | K($urandom_range(0, 15));
      for (int i = 0; i < 4; i++) rb[4*i +: 4] = 4'($urandom_range(0, 9));
      rdy = 1'($urandom_range(0, 1));
      rv  = ($urandom_range(0, 3) == 0);
      tick(kp, rdy, rv, rb);
      n_checks++;
      if (disp_bcd !== exp_disp() || bus.req_valid !== (m_ph == PH_REQ) || ovf !== m_ovf) begin
        n_errors++;
        $display("FAIL rand_out[%0d]: got disp=%h v=%b ovf=%b want %h %b %b", c, disp_bcd, bus.req_valid, ovf,
                 exp_disp(), (m_ph == PH_REQ), m_ovf);
      end
      if (m_ph == PH_REQ) begin
        n_checks++;
        if (bus.req_a !== to_bcd(m_a) || bus.req_b !== to_bcd(m_b) || bus.req_op !== op_t'(m_op)) begin
          n_errors++;
          $display("FAIL rand_req[%0d]: got a=%h b=%h op=%0d want %h %h %0d", c, bus.req_a, bus.req_b, bus.req_op,
                   to_bcd(m_a), to_bcd(m_b), m_op);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    tick('0, 1'b1, 1'b0, '0);
    tick('0, 1'b1, 1'b0, '0);
    tick(K(15), 1'b0, 1'b0, '0);
    tick(K(2), 1'b0, 1'b0, '0);
    tick(K(13), 1'b0, 1'b0, '0);
    tick(K(9), 1'b0, 1'b0, '0);
    tick(K(14), 1'b0, 1'b0, '0);
    n_checks++;
    if (bus.req_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL areset_pre: got valid=%b want 1", bus.req_valid);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_clear();
    n_checks++;
    if (bus.req_valid !== 1'b0 || disp_bcd !== 16'h0) begin
      n_errors++;
      $display("FAIL areset_drop: got valid=%b disp=%h want 0 0000", bus.req_valid, disp_bcd);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(K(5), 1'b0, 1'b0, '0);
    n_checks++;
    if (disp_bcd !== 16'h0005) begin
      n_errors++;
      $display("FAIL areset_resume: got disp=%h want 0005", disp_bcd);
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_basic();
    test_overflow();
    test_stall();
    test_result();
    test_clear_wait();
    test_multi();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
